// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
//
// Memory-mapped 8N1 UART transmitter. This block is the responder on the CPU's
// MMIO port. Software writes bytes to TXDATA, and they are queued in a small
// FIFO. A serialiser drains the FIFO onto o_tx. Software polls STATUS to find
// out whether the FIFO has space.
//
// Register map (word offsets from BASE_ADDR):
//   0 TXDATA  W : i_mask[0] pushes i_data[7:0]. Reads return 0.
//   1 STATUS  R : [0] full, [1] empty, [2] busy, [3] overflow (sticky),
//                 [15:8] FIFO count.
//             W : i_mask[0] with i_data[3]=1 clears overflow.
//   2 DIVISOR RW: [15:0] clocks-per-bit minus one. Each byte lane updates
//                 on its own mask bit.
//   3 reserved  : reads return 0 and writes are ignored.
//
// Ports:
//   clk     system clock; all logic runs on the rising edge
//   rst_n   asynchronous active-low reset
//   i_addr  MMIO word address
//   i_data  MMIO write data
//   i_mask  byte-lane write enables (bit k covers i_data[8k+7:8k])
//   i_wren  single-cycle write strobe
//   o_data  registered read data for the address seen in the previous cycle
//   o_tx    UART serial output, idle high, driven from a flop
// ---------------------------------------------------------------------------
module mmio_uart_tx #(
  parameter logic [29:0] BASE_ADDR  = 30'h0,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] i_addr,
  input  logic [31:0] i_data,
  input  logic [3:0]  i_mask,
  input  logic        i_wren,
  output logic [31:0] o_data,
  output logic        o_tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  // -------------------------------------------------------------------------
  // Address decode and write qualification
  // -------------------------------------------------------------------------
  logic       w_hit;
  logic [1:0] w_reg;
  logic       w_wr_hit;
  logic       w_push_req;
  logic       w_ovf_clr;
  logic       w_div_lo_wr;
  logic       w_div_hi_wr;

  assign w_hit       = (i_addr[29:2] == BASE_ADDR[29:2]);
  assign w_reg       = i_addr[1:0];
  assign w_wr_hit    = i_wren & w_hit;
  assign w_push_req  = w_wr_hit & (w_reg == REG_TXDATA) & i_mask[0];
  assign w_ovf_clr   = w_wr_hit & (w_reg == REG_STATUS) & i_mask[0] & i_data[3];
  assign w_div_lo_wr = w_wr_hit & (w_reg == REG_DIVISOR) & i_mask[0];
  assign w_div_hi_wr = w_wr_hit & (w_reg == REG_DIVISOR) & i_mask[1];

  // The upper data bytes and upper mask bits have no destination.
  logic w_unused_bits;
  assign w_unused_bits = ^{i_data[31:16], i_mask[3:2]};

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  logic [15:0] r_div;
  logic        r_ovf;

  // -------------------------------------------------------------------------
  // TX FIFO
  // -------------------------------------------------------------------------
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;
  logic [7:0] w_head;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];

  // A full FIFO can still take a byte in the same cycle that the serialiser
  // frees a slot. The write then lands in the slot being vacated.
  assign w_push = w_push_req & (~w_full | w_pop);
  assign w_drop = w_push_req & w_full & ~w_pop;

  // NOTE: FIFO storage has no reset. Empty/full state is held entirely in the
  // pointers and count, so the stored bytes never need to be cleared.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data[7:0];
    end
  end

  // NOTE: every clocked process uses non-blocking assignments. All flops then
  // sample their inputs from before the edge, whatever order the processes
  // run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= DIV_RESET;
      r_ovf <= 1'b0;
    end else begin
      if (w_div_lo_wr) begin
        r_div[7:0] <= i_data[7:0];
      end
      if (w_div_hi_wr) begin
        r_div[15:8] <= i_data[15:8];
      end
      // A drop and a clear cannot happen in the same cycle, because they are
      // writes to different registers.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Serialiser
  // -------------------------------------------------------------------------
  state_t      r_state;
  logic [15:0] r_bit_cnt;    // cycles left in the current bit, minus one
  logic [15:0] r_frame_div;  // divisor captured at pop; fixed for the frame
  logic [2:0]  r_bit_idx;    // data bit being sent
  logic [7:0]  r_shift;      // remaining data bits; LSB is on the line
  logic        r_tx;

  state_t      w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic [15:0] w_fdiv_nxt;
  logic [2:0]  w_idx_nxt;
  logic [7:0]  w_shift_nxt;
  logic        w_tx_nxt;

  // NOTE: each output of this block gets a default before the case
  // statement. Every path then assigns every signal, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_fdiv_nxt  = r_frame_div;
    w_idx_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_cnt_nxt   = r_div;
          w_fdiv_nxt  = r_div;
          w_idx_nxt   = 3'd0;
          w_tx_nxt    = 1'b0;
          w_state_nxt = ST_START;
        end
      end

      ST_START: begin
        if (r_bit_cnt == 16'd0) begin
          w_cnt_nxt   = r_frame_div;
          w_idx_nxt   = 3'd0;
          w_tx_nxt    = r_shift[0];
          w_state_nxt = ST_DATA;
        end else begin
          w_cnt_nxt = r_bit_cnt - 16'd1;
        end
      end

      ST_DATA: begin
        if (r_bit_cnt == 16'd0) begin
          w_cnt_nxt = r_frame_div;
          if (r_bit_idx == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = ST_STOP;
          end else begin
            w_idx_nxt   = r_bit_idx + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_cnt_nxt = r_bit_cnt - 16'd1;
        end
      end

      ST_STOP: begin
        if (r_bit_cnt == 16'd0) begin
          if (!w_empty) begin
            // The next frame follows straight on, with no idle bit.
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_cnt_nxt   = r_div;
            w_fdiv_nxt  = r_div;
            w_idx_nxt   = 3'd0;
            w_tx_nxt    = 1'b0;
            w_state_nxt = ST_START;
          end else begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_bit_cnt - 16'd1;
        end
      end

      default: begin
        w_tx_nxt    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_frame_div <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_tx        <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_cnt_nxt;
      r_frame_div <= w_fdiv_nxt;
      r_bit_idx   <= w_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_tx        <= w_tx_nxt;
    end
  end

  assign o_tx = r_tx;

  // -------------------------------------------------------------------------
  // Registered read path (reads have no side effects)
  // -------------------------------------------------------------------------
  logic [7:0]  w_count8;
  logic        w_busy;
  logic [31:0] w_rdata;
  logic [31:0] r_rdata;

  assign w_count8 = 8'(r_count);
  assign w_busy   = (r_state != ST_IDLE);

  always_comb begin
    w_rdata = 32'h0;
    if (w_hit) begin
      case (w_reg)
        REG_STATUS:  w_rdata = {16'h0, w_count8, 4'h0, r_ovf, w_busy, w_empty, w_full};
        REG_DIVISOR: w_rdata = {16'h0, r_div};
        default:     w_rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'h0;
    end else begin
      r_rdata <= w_rdata;
    end
  end

  assign o_data = r_rdata;

endmodule
